// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci term sequencer.
package fib_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } fib_state_t;

    // Default datapath width and term-index width.
    localparam int FIB_WIDTH = 8;
    localparam int FIB_NW    = 5;

    // Index of the largest Fibonacci term that still fits in 'width' bits.
    function automatic int fib_max_index(input int width);
        longint unsigned fa;
        longint unsigned fb;
        longint unsigned ft;
        longint unsigned lim;
        int              idx;
        fa  = 0;
        fb  = 1;
        idx = 0;
        lim = 64'd1 << width;
        for (int i = 0; i < 96; i++) begin
            if (fb >= lim) begin
                return idx;
            end
            ft  = fa + fb;
            fa  = fb;
            fb  = ft;
            idx = idx + 1;
        end
        return idx;
    endfunction

    // Largest representable term index at the default width (13 for 8 bits).
    localparam int FIB_MAX_IDX = fib_max_index(FIB_WIDTH);

endpackage

// File: rtl/fib_seq.sv
// Fibonacci term sequencer: emits F0..Fn one per cycle into a downstream
// result register through d_out/ld_out/clr_out, stopping early with a sticky
// overflow flag when the next term no longer fits in WIDTH bits.
module fib_seq
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int NW    = FIB_NW
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [NW-1:0]    n,
    output logic [WIDTH-1:0] d_out,
    output logic             ld_out,
    output logic             clr_out,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    fib_state_t       state;
    fib_state_t       next_state;

    // a holds the term being emitted, b the next term; b_cy is the carry that
    // b picked up when it was formed, i.e. whether the next term fits at all.
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_cy;
    logic [WIDTH:0]   sum;
    logic [NW-1:0]    cnt;
    logic [NW-1:0]    n_lat;
    logic             last_term;
    logic             accept;

    assign sum       = {1'b0, a} + {1'b0, b};
    assign last_term = (cnt == n_lat);
    assign accept    = (state == IDLE) && start;

    // State register; clr returns the sequencer to IDLE on the next edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the length limit is checked before the overflow so a
    // sequence ending exactly on the largest term finishes cleanly.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = INIT;
                end
            end
            INIT: begin
                next_state = RUN;
            end
            RUN: begin
                if (last_term || b_cy) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Term pair, counter and latched length; RUN advances the pair every edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            a     <= '0;
            b     <= '0;
            b_cy  <= 1'b0;
            cnt   <= '0;
            n_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= n;
                    end
                end
                INIT: begin
                    a    <= '0;
                    b    <= WIDTH'(1);
                    b_cy <= 1'b0;
                    cnt  <= '0;
                end
                RUN: begin
                    a           <= b;
                    {b_cy, b}   <= sum;
                    cnt         <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky overflow flag: set when RUN stops on a term that will not fit,
    // held through IDLE, cleared by the next accepted start or by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if ((state == RUN) && !last_term && b_cy) begin
            ovf <= 1'b1;
        end
    end

    // Moore output decode, forced to the reset values while clr is high so the
    // downstream register is cleared and never loaded during a reset.
    always_comb begin
        clr_out = clr || (state == INIT);
        ld_out  = !clr && (state == RUN);
        busy    = !clr && ((state == INIT) || (state == RUN));
        done    = !clr && (state == DONE);
        d_out   = ld_out ? a : '0;
    end

endmodule

// File: doc/fib_seq.md
Name: fib_seq

Overview:
- Sequencer that generates Fibonacci terms F0..Fn and feeds them, one per cycle, to the 8-bit result register downstream.
- Drives that register's d, ld and clr inputs, and reports busy, done and overflow status to the top level.
- Holds its own term pair (a, b), a term counter and the control FSM.

Parameters:
- WIDTH, 8, width of emitted terms and of the a/b datapath registers.
- NW, 5, width of the term-index input n.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset.
- start  input  1  request a new sequence; sampled only in IDLE.
- n  input  NW  index of the last term to emit; latched on accepted start.
- d_out  output  WIDTH  term value, driven to the result register's d input.
- ld_out  output  1  load strobe to the result register, one cycle per term.
- clr_out  output  1  clear strobe to the result register.
- busy  output  1  high in INIT and RUN.
- done  output  1  one-cycle pulse when the sequence ends.
- ovf  output  1  sticky flag: the sequence stopped because the next term exceeded WIDTH bits.

Behaviour:
- Reset (clr=1 at a rising edge):
  - state=IDLE; a, b, cnt and n_lat cleared; ovf=0.
  - While clr is high: clr_out=1, ld_out=0, done=0, busy=0, d_out=0.
  - Reset mid-sequence aborts immediately; no further ld_out, no done pulse.
- FSM is Moore; outputs decode from registered state only.
- States:
  - IDLE: busy=0, ld_out=0. If start=1, go to INIT, latch n_lat=n and clear ovf. Otherwise stay.
  - INIT (exactly 1 cycle): clr_out=1, busy=1. Loads a=0, b=1, cnt=0. Next state is RUN.
  - RUN: busy=1, ld_out=1, d_out=a. Each edge updates a<=b, b<=a+b (computed WIDTH+1 wide), cnt<=cnt+1.
    - If cnt==n_lat: go to DONE; this is the last term.
    - Else if the carry bit of the value about to become a is set (the next term does not fit): go to DONE and set ovf=1; that term is not emitted.
    - Else stay in RUN.
  - DONE (exactly 1 cycle): done=1, busy=0, ld_out=0. Next state is IDLE.
- Latency:
  - start accepted at edge k: clr_out high in cycle k+1.
  - First ld_out (F0=0) in cycle k+2; last ld_out in cycle k+2+n.
  - done in cycle k+3+n.
- Term count: n+1 loads for n=0..13 at WIDTH=8 (F13=233 is the largest term that fits). For n>=14 the last load is F13, followed by ovf=1.
- n=0: a single load of 0, then done.
- start is ignored while busy or in DONE. start held high continuously re-triggers in the first IDLE cycle after DONE.
- ovf stays set through IDLE until the next accepted start or clr.
- d_out=0 whenever ld_out=0.
- cnt is NW bits wide. It cannot wrap, because the exit condition cnt==n_lat fires first.
- Downstream register timing: that register samples on the falling edge of clk, so d_out and ld_out have half a clock period of setup. No extra pipelining is required.

Decomposition:
- Shared package fib_pkg:
  - state enum fib_state_t {IDLE, INIT, RUN, DONE}
  - default WIDTH=8 and NW=5 constants
  - localparam for the largest representable term index (13 at WIDTH=8), used by the bench.
- No sub-module is natural: the datapath is a single adder plus two registers, kept inline.
- The parent instantiates fib_seq alongside the 8-bit result register and connects d_out, ld_out and clr_out directly to that register.

Test Plan:
- Reset: hold clr=1 for 3 cycles from power-up -> busy=0, done=0, ovf=0, ld_out=0, clr_out=1 during reset; state IDLE afterwards.
- Normal run: start pulse with n=7 -> clr_out one cycle, then 8 consecutive ld_out cycles with d_out=0,1,1,2,3,5,8,13, then a one-cycle done pulse; downstream register ends at 13.
- Edge case n=0 and n=1: n=0 -> one load of 0 then done. n=1 -> loads 0,1 then done. ovf=0 in both.
- Overflow: n=20 -> 14 loads ending with d_out=233, then done=1 and ovf=1. ovf still 1 after 5 idle cycles, cleared by the next start.
- Mid-run abort and ignored start: start with n=10, pulse start again after 2 loads (ignored), assert clr after 4 loads -> ld_out drops the same cycle, no done pulse. A subsequent start with n=3 yields 0,1,1,2.
- Back-to-back: hold start=1 with n=2 -> sequence 0,1,1, done, one IDLE cycle, INIT, then 0,1,1 again.
